// File: rtl/bus_sram_slave.sv
// Word-addressed on-chip SRAM target for the DMA bus master.
// Decodes bursts in its window and serves reads and byte-masked writes.
module bus_sram_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int          ADDR_WIDTH   = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dataIN,
    input  logic [3:0]  byte_enableIN,
    input  logic [7:0]  burst_sizeIN,
    input  logic        read_n_writeIN,
    input  logic        begin_transactionIN,
    input  logic        end_transactionIN,
    input  logic        data_validIN,
    input  logic        busyIN,
    output logic [31:0] address_dataOUT,
    output logic        data_validOUT,
    output logic        end_transactionOUT,
    output logic        busyOUT,
    output logic        errorOUT
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int SUM_W = ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) + 1;
    localparam logic [SUM_W-1:0] LAST_WORD = SUM_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_FETCH,
        ST_READ,
        ST_READ_END,
        ST_WRITE,
        ST_ERR_READ,
        ST_ERR_WRITE,
        ST_DISCARD
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   word_reg, word_next;
    logic [7:0]              remaining_reg, remaining_next;
    logic                    write_done_reg, write_done_next;

    logic                    hit;
    logic [ADDR_WIDTH-1:0]   begin_word;
    logic [SUM_W-1:0]        span;
    logic                    ram_rd_en;
    logic                    ram_wr_en;
    logic [ADDR_WIDTH-1:0]   ram_rd_addr;
    logic [31:0]             ram_rdata;
    logic                    unused_addr_bits;

    // The window is size-aligned, so the word offset is just the low address bits.
    assign hit        = (address_dataIN[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);
    assign begin_word = address_dataIN[ADDR_WIDTH+1:2];
    assign span       = SUM_W'(begin_word) + SUM_W'(burst_sizeIN);
    assign unused_addr_bits = &{1'b0, address_dataIN[1:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            word_reg       <= '0;
            remaining_reg  <= '0;
            write_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            word_reg       <= word_next;
            remaining_reg  <= remaining_next;
            write_done_reg <= write_done_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        word_next          = word_reg;
        remaining_next     = remaining_reg;
        write_done_next    = write_done_reg;
        ram_rd_en          = 1'b0;
        ram_rd_addr        = word_reg;
        ram_wr_en          = 1'b0;
        data_validOUT      = 1'b0;
        end_transactionOUT = 1'b0;
        errorOUT           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (begin_transactionIN && hit) begin
                    word_next       = begin_word;
                    remaining_next  = burst_sizeIN;
                    write_done_next = 1'b0;
                    if (span > LAST_WORD)
                        state_next = read_n_writeIN ? ST_ERR_READ : ST_ERR_WRITE;
                    else
                        state_next = read_n_writeIN ? ST_READ_FETCH : ST_WRITE;
                end
            end
            ST_READ_FETCH: begin
                ram_rd_en  = 1'b1;
                state_next = ST_READ;
            end
            ST_READ: begin
                data_validOUT = 1'b1;
                // Prefetch the next word on each accepted beat; a stall leaves the read register untouched.
                if (!busyIN) begin
                    if (remaining_reg == 8'd0) begin
                        state_next = ST_READ_END;
                    end else begin
                        word_next      = word_reg + ADDR_WIDTH'(1);
                        remaining_next = remaining_reg - 8'd1;
                        ram_rd_en      = 1'b1;
                        ram_rd_addr    = word_reg + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_READ_END: begin
                end_transactionOUT = 1'b1;
                state_next         = ST_IDLE;
            end
            ST_WRITE: begin
                if (data_validIN && !write_done_reg) begin
                    ram_wr_en = 1'b1;
                    word_next = word_reg + ADDR_WIDTH'(1);
                    if (remaining_reg == 8'd0)
                        write_done_next = 1'b1;
                    else
                        remaining_next = remaining_reg - 8'd1;
                end
                if (end_transactionIN)
                    state_next = ST_IDLE;
            end
            ST_ERR_READ: begin
                errorOUT           = 1'b1;
                end_transactionOUT = 1'b1;
                state_next         = ST_IDLE;
            end
            ST_ERR_WRITE: begin
                errorOUT   = 1'b1;
                state_next = end_transactionIN ? ST_IDLE : ST_DISCARD;
            end
            ST_DISCARD: begin
                if (end_transactionIN)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // One byte-wide RAM per lane keeps byte-enable writes a plain block-RAM pattern.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] lane_rdata;
            always_ff @(posedge clock) begin
                if (ram_wr_en && byte_enableIN[gi])
                    mem[word_reg] <= address_dataIN[8*gi +: 8];
                if (ram_rd_en)
                    lane_rdata <= mem[ram_rd_addr];
            end
            assign ram_rdata[8*gi +: 8] = lane_rdata;
        end
    endgenerate

    assign address_dataOUT = data_validOUT ? ram_rdata : 32'h0;
    assign busyOUT         = 1'b0;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Randomized self-checking bench for bus_sram_slave against a word-array model.
module tb_bus_sram_slave;

    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam int          WORDS = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dataIN;
    logic [3:0]  byte_enableIN;
    logic [7:0]  burst_sizeIN;
    logic        read_n_writeIN;
    logic        begin_transactionIN;
    logic        end_transactionIN;
    logic        data_validIN;
    logic        busyIN;
    logic [31:0] address_dataOUT;
    logic        data_validOUT;
    logic        end_transactionOUT;
    logic        busyOUT;
    logic        errorOUT;

    bus_sram_slave #(.BASE_ADDRESS(BASE), .ADDR_WIDTH(10)) dut (
        .clock(clock), .reset(reset),
        .address_dataIN(address_dataIN), .byte_enableIN(byte_enableIN),
        .burst_sizeIN(burst_sizeIN), .read_n_writeIN(read_n_writeIN),
        .begin_transactionIN(begin_transactionIN), .end_transactionIN(end_transactionIN),
        .data_validIN(data_validIN), .busyIN(busyIN),
        .address_dataOUT(address_dataOUT), .data_validOUT(data_validOUT),
        .end_transactionOUT(end_transactionOUT), .busyOUT(busyOUT), .errorOUT(errorOUT)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem   [WORDS];
    bit          ref_known [WORDS];

    logic [31:0] wr_data [$];
    logic [3:0]  wr_be   [$];
    logic [31:0] rd_beats [$];
    int rd_first, rd_end, rd_err, rd_stalls, rd_hold_bad, rd_or_bad;
    int wr_err_first, wr_err_cnt, wr_out_bad;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic start(input logic [31:0] addr, input logic [7:0] burst, input logic rnw);
        address_dataIN      = addr;
        burst_sizeIN        = burst;
        read_n_writeIN      = rnw;
        begin_transactionIN = 1'b1;
        step();
        begin_transactionIN = 1'b0;
        address_dataIN      = 32'h0;
        burst_sizeIN        = 8'h0;
        read_n_writeIN      = 1'b0;
    endtask

    // Reference: a write is accepted only inside the window and only if the whole burst fits.
    task automatic model_write(input logic [31:0] addr, input logic [7:0] burst, input int nbeats);
        int word;
        if (addr < BASE || addr >= BASE + 32'd4096) return;
        word = int'((addr - BASE) / 4);
        if (word + int'(burst) > WORDS - 1) return;
        for (int i = 0; i < nbeats && i <= int'(burst); i++) begin
            for (int b = 0; b < 4; b++)
                if (wr_be[i][b]) ref_mem[word + i][8*b +: 8] = wr_data[i][8*b +: 8];
            if (wr_be[i] == 4'hF) ref_known[word + i] = 1'b1;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] burst, input bit gaps);
        wr_err_cnt = 0;
        wr_out_bad = 0;
        start(addr, burst, 1'b0);
        wr_err_first = int'(errorOUT);
        for (int i = 0; i <= wr_data.size(); i++) begin
            if (errorOUT) wr_err_cnt++;
            if (data_validOUT || end_transactionOUT || busyOUT || address_dataOUT != 32'h0) wr_out_bad++;
            if (i == wr_data.size()) break;
            if (gaps && $urandom_range(0, 2) == 0) begin
                data_validIN = 1'b0;
                step();
                if (errorOUT) wr_err_cnt++;
            end
            data_validIN   = 1'b1;
            address_dataIN = wr_data[i];
            byte_enableIN  = wr_be[i];
            step();
        end
        data_validIN      = 1'b0;
        address_dataIN    = 32'h0;
        byte_enableIN     = 4'h0;
        end_transactionIN = 1'b1;
        step();
        if (errorOUT) wr_err_cnt++;
        end_transactionIN = 1'b0;
        model_write(addr, burst, wr_data.size());
        $display("write addr=%h burst=%0d beats=%0d error_pulses=%0d", addr, burst, wr_data.size(), wr_err_cnt);
    endtask

    // mode 0: no stall, 1: stall_len cycles at beat stall_at, 2: random stalls.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] burst, input int mode,
                           input int stall_at, input int stall_len, input int budget);
        bit          prev_stalled = 1'b0;
        logic [31:0] prev_data = 32'h0;
        int          stall_run = 0;
        bit          stall;
        rd_beats.delete();
        rd_first = -1; rd_end = -1; rd_err = -1;
        rd_stalls = 0; rd_hold_bad = 0; rd_or_bad = 0;
        start(addr, burst, 1'b1);
        for (int k = 1; k <= budget; k++) begin
            if (!data_validOUT && address_dataOUT != 32'h0) rd_or_bad++;
            if (errorOUT && rd_err < 0) rd_err = k;
            busyIN = 1'b0;
            if (data_validOUT) begin
                if (rd_first < 0) rd_first = k;
                if (prev_stalled && address_dataOUT !== prev_data) rd_hold_bad++;
                stall = (mode == 1 && rd_beats.size() == stall_at && stall_run < stall_len) ||
                        (mode == 2 && $urandom_range(0, 3) == 0);
                if (stall) begin
                    busyIN = 1'b1;
                    rd_stalls++;
                    stall_run++;
                    prev_data = address_dataOUT;
                end else begin
                    rd_beats.push_back(address_dataOUT);
                end
                prev_stalled = stall;
            end
            if (end_transactionOUT) begin
                rd_end = k;
                break;
            end
            step();
        end
        busyIN = 1'b0;
        step();
        $display("read  addr=%h burst=%0d beats=%0d stalls=%0d end_at=T+%0d error_at=T+%0d",
                 addr, burst, rd_beats.size(), rd_stalls, rd_end, rd_err);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        address_dataIN = 32'h0; byte_enableIN = 4'h0; burst_sizeIN = 8'h0;
        read_n_writeIN = 1'b0; begin_transactionIN = 1'b0; end_transactionIN = 1'b0;
        data_validIN = 1'b0; busyIN = 1'b0;
        #1 reset = 1'b0;
        step();
        step();
        checks++;
        if ({data_validOUT, end_transactionOUT, busyOUT, errorOUT, address_dataOUT} !== 36'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {data_validOUT, end_transactionOUT, busyOUT, errorOUT, address_dataOUT});
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        wr_data = '{32'hDEAD_BEEF}; wr_be = '{4'hF};
        do_write(BASE + 32'h10, 8'd0, 1'b0);
        checks++; if (wr_err_cnt != 0 || wr_out_bad != 0) begin failures++; $display("FAIL single_write_outputs err=%0d other=%0d want=0", wr_err_cnt, wr_out_bad); end
        do_read(BASE + 32'h10, 8'd0, 0, 0, 0, 12);
        checks++; if (rd_first != 2) begin failures++; $display("FAIL single_first_valid got=T+%0d want=T+2", rd_first); end
        checks++; if (rd_beats.size() != 1) begin failures++; $display("FAIL single_beat_count got=%0d want=1", rd_beats.size()); end
        else begin checks++; if (rd_beats[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_data got=%h want=deadbeef", rd_beats[0]); end end
        checks++; if (rd_end != 3) begin failures++; $display("FAIL single_end got=T+%0d want=T+3", rd_end); end
        checks++; if (end_transactionOUT !== 1'b0) begin failures++; $display("FAIL single_end_pulse_width got=%b want=0", end_transactionOUT); end
    endtask

    task automatic test_byte_enable();
        wr_data = '{32'h1122_3344}; wr_be = '{4'hF};
        do_write(BASE + 32'h20, 8'd0, 1'b0);
        wr_data = '{32'hAABB_CCDD}; wr_be = '{4'b0101};
        do_write(BASE + 32'h20, 8'd0, 1'b0);
        do_read(BASE + 32'h20, 8'd0, 0, 0, 0, 12);
        checks++; if (rd_beats.size() != 1) begin failures++; $display("FAIL be_beat_count got=%0d want=1", rd_beats.size()); end
        else begin checks++; if (rd_beats[0] !== 32'h11BB_33DD) begin failures++; $display("FAIL be_mask got=%h want=11bb33dd", rd_beats[0]); end end
    endtask

    task automatic test_burst_stall();
        wr_data.delete(); wr_be.delete();
        for (int i = 0; i < 16; i++) begin wr_data.push_back(32'(i)); wr_be.push_back(4'hF); end
        do_write(BASE, 8'd15, 1'b1);
        do_read(BASE, 8'd15, 1, 5, 3, 60);
        checks++; if (rd_beats.size() != 16) begin failures++; $display("FAIL stall_beat_count got=%0d want=16", rd_beats.size()); end
        for (int i = 0; i < rd_beats.size() && i < 16; i++) begin
            checks++; if (rd_beats[i] !== 32'(i)) begin failures++; $display("FAIL stall_beat%0d got=%h want=%h", i, rd_beats[i], i); end
        end
        checks++; if (rd_stalls != 3 || rd_hold_bad != 0) begin failures++; $display("FAIL stall_hold stalls=%0d unstable=%0d want 3/0", rd_stalls, rd_hold_bad); end
        checks++; if (rd_first != 2) begin failures++; $display("FAIL stall_first_valid got=T+%0d want=T+2", rd_first); end
        checks++; if (rd_end != 16 + 2 + 3) begin failures++; $display("FAIL stall_end got=T+%0d want=T+%0d", rd_end, 16 + 2 + 3); end
    endtask

    task automatic test_bounds();
        wr_data = '{32'hCAFE_0FF8, 32'hCAFE_0FFC}; wr_be = '{4'hF, 4'hF};
        do_write(BASE + 32'hFF8, 8'd1, 1'b0);
        checks++; if (wr_err_cnt != 0) begin failures++; $display("FAIL bound_edge_write err_pulses=%0d want=0", wr_err_cnt); end
        do_read(BASE + 32'hFFC, 8'd0, 0, 0, 0, 12);
        checks++; if (rd_beats.size() != 1 || rd_err != -1) begin failures++; $display("FAIL bound_last_word beats=%0d err_at=%0d want 1/-1", rd_beats.size(), rd_err); end
        else begin checks++; if (rd_beats[0] !== ref_mem[WORDS-1]) begin failures++; $display("FAIL bound_last_data got=%h want=%h", rd_beats[0], ref_mem[WORDS-1]); end end
        do_read(BASE + 32'hFFC, 8'd1, 0, 0, 0, 12);
        checks++; if (rd_err != 1 || rd_end != 1) begin failures++; $display("FAIL bound_read_error err_at=T+%0d end_at=T+%0d want T+1/T+1", rd_err, rd_end); end
        checks++; if (rd_first != -1 || rd_or_bad != 0) begin failures++; $display("FAIL bound_read_error_data first=%0d stray=%0d want -1/0", rd_first, rd_or_bad); end
        do_read(32'h6000_0000, 8'd0, 0, 0, 0, 8);
        checks++; if (rd_first != -1 || rd_end != -1 || rd_err != -1 || rd_or_bad != 0) begin
            failures++; $display("FAIL bound_miss first=%0d end=%0d err=%0d stray=%0d want all -1/0", rd_first, rd_end, rd_err, rd_or_bad); end
        wr_data = '{32'h1, 32'h2, 32'h3, 32'h4}; wr_be = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(BASE + 32'hFF8, 8'd3, 1'b0);
        checks++; if (wr_err_first != 1 || wr_err_cnt != 1) begin failures++; $display("FAIL bound_write_error first=%0d pulses=%0d want 1/1", wr_err_first, wr_err_cnt); end
        do_read(BASE + 32'hFF8, 8'd1, 0, 0, 0, 12);
        checks++; if (rd_beats.size() != 2) begin failures++; $display("FAIL bound_untouched_count got=%0d want=2", rd_beats.size()); end
        else begin checks++; if (rd_beats[0] !== ref_mem[WORDS-2] || rd_beats[1] !== ref_mem[WORDS-1]) begin
            failures++; $display("FAIL bound_untouched got=%h,%h want=%h,%h", rd_beats[0], rd_beats[1], ref_mem[WORDS-2], ref_mem[WORDS-1]); end end
    endtask

    task automatic test_early_end();
        wr_data.delete(); wr_be.delete();
        for (int i = 0; i < 8; i++) begin wr_data.push_back(32'hA000_0000 + 32'(i)); wr_be.push_back(4'hF); end
        do_write(BASE + 32'h80, 8'd7, 1'b0);
        wr_data = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002}; wr_be = '{4'hF, 4'hF, 4'hF};
        do_write(BASE + 32'h80, 8'd7, 1'b1);
        do_read(BASE + 32'h80, 8'd7, 0, 0, 0, 20);
        checks++; if (rd_first != 2 || rd_beats.size() != 8) begin failures++; $display("FAIL early_end_next_begin first=T+%0d beats=%0d want T+2/8", rd_first, rd_beats.size()); end
        for (int i = 0; i < rd_beats.size() && i < 8; i++) begin
            checks++; if (rd_beats[i] !== ref_mem[32 + i]) begin failures++; $display("FAIL early_end_word%0d got=%h want=%h", i, rd_beats[i], ref_mem[32 + i]); end
        end
    endtask

    task automatic test_random();
        int start_word, burst, nb;
        wr_data.delete(); wr_be.delete();
        for (int i = 0; i < 64; i++) begin wr_data.push_back($urandom); wr_be.push_back(4'hF); end
        do_write(BASE + 32'd256, 8'd63, 1'b1);
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                burst = $urandom_range(0, 7);
                start_word = $urandom_range(64, 127 - burst - 2);
                nb = $urandom_range(1, burst + 3);
                wr_data.delete(); wr_be.delete();
                for (int i = 0; i < nb; i++) begin wr_data.push_back($urandom); wr_be.push_back(4'($urandom_range(0, 15))); end
                do_write(BASE + 32'(start_word * 4), 8'(burst), 1'b1);
                checks++; if (wr_err_cnt != 0 || wr_out_bad != 0) begin failures++; $display("FAIL rand_write_outputs err=%0d other=%0d want=0", wr_err_cnt, wr_out_bad); end
            end else begin
                burst = $urandom_range(0, 15);
                start_word = $urandom_range(64, 127 - burst);
                do_read(BASE + 32'(start_word * 4), 8'(burst), 2, 0, 0, 120);
                checks++; if (rd_beats.size() != burst + 1) begin failures++; $display("FAIL rand_read_count got=%0d want=%0d", rd_beats.size(), burst + 1); end
                for (int i = 0; i < rd_beats.size() && i <= burst; i++) begin
                    checks++; if (rd_beats[i] !== ref_mem[start_word + i]) begin failures++; $display("FAIL rand_read_word%0d got=%h want=%h", start_word + i, rd_beats[i], ref_mem[start_word + i]); end
                end
                checks++; if (rd_end != burst + 3 + rd_stalls || rd_hold_bad != 0 || rd_or_bad != 0) begin
                    failures++; $display("FAIL rand_read_timing end=T+%0d want=T+%0d unstable=%0d stray=%0d", rd_end, burst + 3 + rd_stalls, rd_hold_bad, rd_or_bad); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int nvalid = 0;
        start(BASE, 8'd15, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            if (data_validOUT) nvalid++;
            if (nvalid == 4) break;
            step();
        end
        checks++; if (nvalid != 4) begin failures++; $display("FAIL reset_mid_reach_beat4 got=%0d want=4", nvalid); end
        reset = 1'b0;
        #1;
        checks++; if ({data_validOUT, end_transactionOUT, busyOUT, errorOUT, address_dataOUT} !== 36'h0) begin
            failures++; $display("FAIL reset_mid_outputs got=%h want=0", {data_validOUT, end_transactionOUT, busyOUT, errorOUT, address_dataOUT}); end
        $display("reset asserted during read beat 4");
        step();
        reset = 1'b1;
        step();
        do_read(BASE, 8'd15, 0, 0, 0, 40);
        checks++; if (rd_beats.size() != 16 || rd_end != 18) begin failures++; $display("FAIL reset_mid_readback beats=%0d end=T+%0d want 16/T+18", rd_beats.size(), rd_end); end
        for (int i = 0; i < rd_beats.size() && i < 16; i++) begin
            checks++; if (rd_beats[i] !== ref_mem[i]) begin failures++; $display("FAIL reset_mid_word%0d got=%h want=%h", i, rd_beats[i], ref_mem[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin ref_mem[i] = 32'h0; ref_known[i] = 1'b0; end
        test_reset();
        test_single();
        test_byte_enable();
        test_burst_stall();
        test_bounds();
        test_early_end();
        test_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
